fifo_rd_arbiter: RTL and testbench

FIFO_RD_ARBITER -- requirements
Module: fifo_rd_arbiter

---
 rtl/fifo_rd_arb_pkg.sv | 19 +
 rtl/rr_pick.sv | 57 +++++
 rtl/fifo_rd_arbiter.sv | 97 +++++++++
 tb/tb_fifo_rd_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_arb_pkg.sv
// Shared types and sizing helpers for the FIFO read-port arbiter.
package fifo_rd_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_e;

   localparam int unsigned DEF_ADDR_SIZE = 4;
   localparam int unsigned DEF_DATA_SIZE = 8;
   localparam int unsigned DEF_NUM_REQ   = 4;
   localparam int unsigned DEF_MAX_BURST = 4;

   // Counter must reach MAX_BURST itself, hence one bit beyond clog2.
   function automatic int unsigned cnt_width(input int unsigned max_burst);
      return $clog2(max_burst) + 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Winner selection for the read-port arbiter; round-robin with an owned pointer,
// or fixed lowest-index priority when FIFO_RD_ARB_FIXED_PRIO_EN is defined.
module rr_pick
   import fifo_rd_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = DEF_NUM_REQ
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic [NUM_REQ-1:0] req_i,
   input  logic               upd_i,
   output logic [NUM_REQ-1:0] win_c_o
);

   localparam int unsigned IW = $clog2(NUM_REQ);

   logic [IW-1:0] win_idx_c;
   logic          found_c;
   int unsigned   base_c;
   int unsigned   idx_c;

`ifdef FIFO_RD_ARB_FIXED_PRIO_EN
   logic unused_c;

   assign base_c   = 32'd0;
   assign unused_c = ^{clk_i, rst_ni, upd_i, win_idx_c};
`else
   logic [IW-1:0] ptr_q;

   // Search begins one past the last grant holder.
   assign base_c = 32'(ptr_q) + 32'd1;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         ptr_q <= IW'(NUM_REQ - 1);
      end else if (upd_i && found_c) begin
         ptr_q <= win_idx_c;
      end
   end
`endif

   always_comb begin
      win_c_o   = '0;
      win_idx_c = '0;
      found_c   = 1'b0;
      idx_c     = 0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         idx_c = (base_c + i) % NUM_REQ;
         if (!found_c && req_i[IW'(idx_c)]) begin
            win_c_o[IW'(idx_c)] = 1'b1;
            win_idx_c           = IW'(idx_c);
            found_c             = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Shares one FIFO read port among NUM_REQ consumers in bursts of up to MAX_BURST pops.
// Define FIFO_RD_ARB_FIXED_PRIO_EN for fixed priority instead of round-robin.
module fifo_rd_arbiter
   import fifo_rd_arb_pkg::*;
#(
   parameter int unsigned ADDR_SIZE = DEF_ADDR_SIZE,
   parameter int unsigned DATA_SIZE = DEF_DATA_SIZE,
   parameter int unsigned NUM_REQ   = DEF_NUM_REQ,
   parameter int unsigned MAX_BURST = DEF_MAX_BURST
) (
   input  logic                 r_clk,
   input  logic                 r_rst,
   input  logic [NUM_REQ-1:0]   req,
   input  logic                 r_empty,
   input  logic [DATA_SIZE-1:0] r_data,
   output logic                 r_en,
   output logic [NUM_REQ-1:0]   gnt,
   output logic [DATA_SIZE-1:0] dout,
   output logic [NUM_REQ-1:0]   dout_vld
);

   localparam int unsigned CW = cnt_width(MAX_BURST);

   arb_state_e           state_q;
   logic [NUM_REQ-1:0]   gnt_q;
   logic [CW-1:0]        cnt_q;
   logic [DATA_SIZE-1:0] dout_q;
   logic [NUM_REQ-1:0]   dout_vld_q;

   logic [NUM_REQ-1:0]   win_c;
   logic                 own_req_c;
   logic                 arb_go_c;
   logic [CW-1:0]        cnt_nxt_c;
   logic                 last_pop_c;
   logic [ADDR_SIZE-1:0] unused_addr_c;

   assign unused_addr_c = '0;

   rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_pick (
      .clk_i   (r_clk),
      .rst_ni  (r_rst),
      .req_i   (req),
      .upd_i   (arb_go_c),
      .win_c_o (win_c)
   );

   assign own_req_c  = |(req & gnt_q);
   assign arb_go_c   = r_rst & (state_q == IDLE) & (|req) & ~r_empty;
   // Pop is gated by reset and empty in the same cycle so no underflow can occur.
   assign r_en       = r_rst & (state_q == BURST) & own_req_c & ~r_empty;
   assign cnt_nxt_c  = cnt_q + CW'(1);
   assign last_pop_c = r_en & (cnt_nxt_c == CW'(MAX_BURST));

   always_ff @(posedge r_clk) begin
      if (!r_rst) begin
         state_q    <= IDLE;
         gnt_q      <= '0;
         cnt_q      <= '0;
         dout_q     <= '0;
         dout_vld_q <= '0;
      end else begin
         dout_vld_q <= '0;
         if (r_en) begin
            dout_q     <= r_data;
            dout_vld_q <= gnt_q;
            cnt_q      <= cnt_nxt_c;
         end
         case (state_q)
            IDLE: begin
               if (arb_go_c) begin
                  state_q <= BURST;
                  gnt_q   <= win_c;
                  cnt_q   <= '0;
               end
            end
            BURST: begin
               // Ending straight to IDLE guarantees a gap cycle before the next grant.
               if (last_pop_c || !own_req_c || r_empty) begin
                  state_q <= IDLE;
                  gnt_q   <= '0;
               end
            end
            default: begin
               state_q <= IDLE;
               gnt_q   <= '0;
            end
         endcase
      end
   end

   assign gnt      = gnt_q;
   assign dout     = dout_q;
   assign dout_vld = dout_vld_q;

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Scoreboard bench for fifo_rd_arbiter: directed bursts against a FIFO model.
module tb_fifo_rd_arbiter;

   typedef struct packed {
      logic [3:0] vld;
      logic [7:0] data;
   } item_t;

   logic       r_clk = 1'b0;
   logic       r_rst;
   logic [3:0] req;
   logic       r_empty;
   logic [7:0] r_data;
   logic       r_en;
   logic [3:0] gnt;
   logic [7:0] dout;
   logic [3:0] dout_vld;

   logic [7:0] mem [0:255];
   int         rd_ptr = 0;
   int         wr_ptr = 0;
   logic       flush  = 1'b1;

   item_t      exp_q[$];
   logic [3:0] gnt_exp_q[$];
   item_t      exp_item;
   logic [3:0] gnt_item;
   logic [3:0] prev_gnt = '0;
   int         vectors = 0;
   int         miscompares = 0;
   int         pops = 0;
   logic [3:0] seq [0:4];

   always #5 r_clk = ~r_clk;

   fifo_rd_arbiter #(
      .ADDR_SIZE (4),
      .DATA_SIZE (8),
      .NUM_REQ   (4),
      .MAX_BURST (4)
   ) dut (
      .r_clk    (r_clk),
      .r_rst    (r_rst),
      .req      (req),
      .r_empty  (r_empty),
      .r_data   (r_data),
      .r_en     (r_en),
      .gnt      (gnt),
      .dout     (dout),
      .dout_vld (dout_vld)
   );

   // FIFO read-side model
   assign r_empty = (rd_ptr == wr_ptr);
   assign r_data  = mem[rd_ptr[7:0]];

   always @(posedge r_clk) begin
      if (flush) rd_ptr <= wr_ptr;
      else if (r_en) rd_ptr <= rd_ptr + 1;
   end

   // Monitor: scoreboard for data, grant order and per-cycle invariants
   always @(negedge r_clk) begin
      if (r_en) pops++;
      if (dout_vld != 4'b0000) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL dout_unexpected: got vld=%b data=%h, required no strobe", dout_vld, dout);
         end else begin
            exp_item = exp_q.pop_front();
            if (dout_vld !== exp_item.vld || dout !== exp_item.data) begin
               miscompares++;
               $display("FAIL dout: got vld=%b data=%h, required vld=%b data=%h",
                        dout_vld, dout, exp_item.vld, exp_item.data);
            end
         end
      end
      if (gnt != 4'b0000 && prev_gnt == 4'b0000) begin
         vectors++;
         if (gnt_exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL gnt_unexpected: got %b, required no grant", gnt);
         end else begin
            gnt_item = gnt_exp_q.pop_front();
            if (gnt !== gnt_item) begin
               miscompares++;
               $display("FAIL gnt_order: got %b, required %b", gnt, gnt_item);
            end
         end
      end
      if (gnt != 4'b0000 && prev_gnt != 4'b0000 && gnt != prev_gnt) begin
         vectors++;
         miscompares++;
         $display("FAIL gnt_gap: got %b directly after %b, required an idle cycle", gnt, prev_gnt);
      end
      if (r_en) begin
         vectors++;
         if (!r_rst || r_empty || (gnt & req) == 4'b0000) begin
            miscompares++;
            $display("FAIL ren_legal: got r_en=1 with rst=%b empty=%b gnt=%b req=%b, required r_en=0",
                     r_rst, r_empty, gnt, req);
         end
      end
      if (!$onehot0(gnt) || !$onehot0(dout_vld)) begin
         vectors++;
         miscompares++;
         $display("FAIL onehot: got gnt=%b dout_vld=%b, required one-hot or zero", gnt, dout_vld);
      end
      prev_gnt = gnt;
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, required %0h", name, got, exp);
      end
   endtask

   task automatic do_reset();
      @(posedge r_clk); #1;
      r_rst = 1'b0;
      flush = 1'b1;
      req   = 4'b0000;
      @(posedge r_clk); #1;
      @(negedge r_clk);
      check("rst_gnt", 32'(gnt), 32'h0);
      check("rst_dout_vld", 32'(dout_vld), 32'h0);
      check("rst_dout", 32'(dout), 32'h0);
      check("rst_ren", 32'(r_en), 32'h0);
      @(posedge r_clk); #1;
      r_rst = 1'b1;
      flush = 1'b0;
      pops  = 0;
   endtask

   task automatic load(input logic [7:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         mem[wr_ptr[7:0]] = base + 8'(i);
         wr_ptr++;
      end
   endtask

   task automatic wait_pop(input string name);
      bit seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge r_clk);
         if (r_en) seen = 1'b1;
      end
      if (!seen) begin
         vectors++;
         miscompares++;
         $display("FAIL %s_timeout: got no r_en in 50 cycles, required a pop", name);
      end
   endtask

   task automatic end_test(input string name, input int exp_pops);
      check({name, "_pops"}, 32'(pops), 32'(exp_pops));
      check({name, "_data_left"}, 32'(exp_q.size()), 32'h0);
      check({name, "_gnt_left"}, 32'(gnt_exp_q.size()), 32'h0);
      exp_q.delete();
      gnt_exp_q.delete();
   endtask

   initial begin
      r_rst = 1'b0;
      req   = 4'b0000;

      do_reset();

      // Single consumer: 6 words split into bursts of 4 and 2
      load(8'h10, 6);
      for (int i = 0; i < 6; i++) exp_q.push_back('{4'b0001, 8'h10 + 8'(i)});
      gnt_exp_q.push_back(4'b0001);
      gnt_exp_q.push_back(4'b0001);
      req = 4'b0001;
      repeat (30) @(posedge r_clk);
      #1 req = 4'b0000;
      end_test("single", 6);

      // All requesting, FIFO stays non-empty for 20 pops
      do_reset();
`ifdef FIFO_RD_ARB_FIXED_PRIO_EN
      seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
      seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
      load(8'h20, 20);
      for (int g = 0; g < 5; g++) begin
         gnt_exp_q.push_back(seq[g]);
         for (int k = 0; k < 4; k++) exp_q.push_back('{seq[g], 8'h20 + 8'(4 * g + k)});
      end
      req = 4'b1111;
      repeat (40) @(posedge r_clk);
      #1 req = 4'b0000;
      end_test("all_req", 20);

      // Empty mid-burst: only 2 words available
      do_reset();
      load(8'h60, 2);
      exp_q.push_back('{4'b0100, 8'h60});
      exp_q.push_back('{4'b0100, 8'h61});
      gnt_exp_q.push_back(4'b0100);
      req = 4'b0100;
      repeat (6) @(posedge r_clk);
      #1;
      check("empty_gnt", 32'(gnt), 32'h0);
      repeat (4) @(posedge r_clk);
      #1 req = 4'b0000;
      end_test("empty", 2);

      // Request dropped after the first pop
      do_reset();
      load(8'h30, 4);
      exp_q.push_back('{4'b0010, 8'h30});
      gnt_exp_q.push_back(4'b0010);
      req = 4'b0010;
      wait_pop("drop");
      @(posedge r_clk); #1;
      req = 4'b0000;
      @(negedge r_clk);
      check("drop_ren", 32'(r_en), 32'h0);
      check("drop_gnt_held", 32'(gnt), 32'h2);
      @(negedge r_clk);
      check("drop_gnt_clr", 32'(gnt), 32'h0);
      repeat (5) @(posedge r_clk);
      #1;
      end_test("drop", 1);

      // Reset pulse during the second pop of a burst
      do_reset();
      load(8'h50, 6);
      exp_q.push_back('{4'b0001, 8'h50});
      for (int i = 1; i < 5; i++) exp_q.push_back('{4'b0001, 8'h50 + 8'(i)});
`ifdef FIFO_RD_ARB_FIXED_PRIO_EN
      exp_q.push_back('{4'b0001, 8'h55});
      gnt_exp_q = '{4'b0001, 4'b0001, 4'b0001};
`else
      exp_q.push_back('{4'b0010, 8'h55});
      gnt_exp_q = '{4'b0001, 4'b0001, 4'b0010};
`endif
      req = 4'b0001;
      wait_pop("rstmid");
      @(posedge r_clk); #1;
      r_rst = 1'b0;
      @(negedge r_clk);
      check("rstmid_ren", 32'(r_en), 32'h0);
      @(posedge r_clk); #1;
      r_rst = 1'b1;
      req   = 4'b1111;
      @(negedge r_clk);
      check("rstmid_gnt", 32'(gnt), 32'h0);
      check("rstmid_vld", 32'(dout_vld), 32'h0);
      check("rstmid_ren2", 32'(r_en), 32'h0);
      repeat (20) @(posedge r_clk);
      #1 req = 4'b0000;
      end_test("rstmid", 6);

      // Two requesters 1 and 3
      do_reset();
`ifdef FIFO_RD_ARB_FIXED_PRIO_EN
      seq = '{4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
`else
      seq = '{4'b0010, 4'b1000, 4'b0010, 4'b0000, 4'b0000};
`endif
      load(8'h80, 12);
      for (int g = 0; g < 3; g++) begin
         gnt_exp_q.push_back(seq[g]);
         for (int k = 0; k < 4; k++) exp_q.push_back('{seq[g], 8'h80 + 8'(4 * g + k)});
      end
      req = 4'b1010;
      repeat (30) @(posedge r_clk);
      #1 req = 4'b0000;
      end_test("pair", 12);

      repeat (3) @(posedge r_clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
